// File: rtl/ghost_catch_ctrl.sv
// Catch detection and round FSM for the ghost/Pacman game.
// Compares one ghost against Pacman each cycle, and owns the round flow
// (idle, play, caught-freeze, respawn, over) and the lives counter.
module ghost_catch_ctrl #(
  parameter int LIVES         = 3,
  parameter int HIT_DIST      = 8,
  parameter int FREEZE_CYCLES = 50000000,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,        // active-low, asynchronous
  input  logic       start,
  input  logic [9:0] pac_x,
  input  logic [8:0] pac_y,
  input  logic [9:0] ghost_x,
  input  logic [8:0] ghost_y,
  output logic       freeze,
  output logic       respawn,
  output logic       caught,
  output logic [2:0] lives,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    CAUGHT  = 3'd2,
    RESPAWN = 3'd3,
    OVER    = 3'd4
  } state_t;

  localparam logic [2:0]       LIVES_L = 3'(LIVES);
  localparam logic [9:0]       HIT_X   = 10'(HIT_DIST);
  localparam logic [8:0]       HIT_Y   = 9'(HIT_DIST);
  localparam logic [CNT_W-1:0] TMR_END = CNT_W'(FREEZE_CYCLES - 1);

  state_t           st, st_nxt;
  logic [2:0]       lives_nxt;
  logic [CNT_W-1:0] tmr, tmr_nxt;
  logic             caught_nxt, respawn_nxt;
  logic             hit_q;
  logic [9:0]       dx;
  logic [8:0]       dy;
  logic             overlap;

  // Per-axis absolute distance, larger minus smaller so nothing wraps.
  always_comb begin
    dx      = (pac_x >= ghost_x) ? (pac_x - ghost_x) : (ghost_x - pac_x);
    dy      = (pac_y >= ghost_y) ? (pac_y - ghost_y) : (ghost_y - pac_y);
    overlap = (dx < HIT_X) && (dy < HIT_Y);
  end

  // Catch flag, only armed in PLAY so the cycle after RESPAWN never sees a stale hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hit_q <= 1'b0;
    else      hit_q <= (st == PLAY) && overlap;
  end

  // Next-state, lives, freeze timer and the one-cycle pulses.
  always_comb begin
    st_nxt      = st;
    lives_nxt   = lives;
    tmr_nxt     = tmr;
    caught_nxt  = 1'b0;
    respawn_nxt = 1'b0;
    case (st)
      IDLE: if (start) begin
        st_nxt    = PLAY;
        lives_nxt = LIVES_L;
      end
      PLAY: if (hit_q) begin
        st_nxt     = CAUGHT;
        lives_nxt  = lives - 3'd1;   // PLAY is never entered with zero lives
        tmr_nxt    = '0;
        caught_nxt = 1'b1;
      end
      CAUGHT: begin
        if (tmr == TMR_END) begin
          if (lives != 3'd0) begin
            st_nxt      = RESPAWN;
            respawn_nxt = 1'b1;
          end else begin
            st_nxt = OVER;
          end
        end else begin
          tmr_nxt = tmr + CNT_W'(1);
        end
      end
      RESPAWN: st_nxt = PLAY;
      OVER: if (start) begin
        st_nxt      = PLAY;
        lives_nxt   = LIVES_L;
        respawn_nxt = 1'b1;          // restart reloads movers in the same cycle
      end
      default: st_nxt = IDLE;
    endcase
  end

  // State, lives, timer and registered pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      lives   <= LIVES_L;
      tmr     <= '0;
      caught  <= 1'b0;
      respawn <= 1'b0;
    end else begin
      st      <= st_nxt;
      lives   <= lives_nxt;
      tmr     <= tmr_nxt;
      caught  <= caught_nxt;
      respawn <= respawn_nxt;
    end
  end

  assign freeze    = (st != PLAY);
  assign game_over = (st == OVER);
  assign state     = st;

endmodule

// File: tb/tb_ghost_catch_ctrl.sv
// Bench for ghost_catch_ctrl: directed round walk-through, randomized play
// against a round-level reference model, and an async reset mid-freeze.
module tb_ghost_catch_ctrl;
  localparam int LIVES = 3, HIT = 8, FRZ = 4;

  logic       clk = 0, rst = 0, start = 0;
  logic [9:0] pac_x = 0, ghost_x = 0;
  logic [8:0] pac_y = 0, ghost_y = 0;
  logic       freeze, respawn, caught, game_over;
  logic [2:0] lives, state;

  int n_chk = 0, n_err = 0;

  ghost_catch_ctrl #(.LIVES(LIVES), .HIT_DIST(HIT), .FREEZE_CYCLES(FRZ), .CNT_W(26)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .freeze(freeze), .respawn(respawn), .caught(caught), .lives(lives),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  // Round-level model: phase name, lives, freeze cycles still to spend,
  // whether a catch was seen last cycle, and the pulses due this cycle.
  int m_st, m_lives, m_left;
  bit m_hit, m_caught, m_resp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_lives = LIVES; m_left = 0; m_hit = 0; m_caught = 0; m_resp = 0;
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_step(input bit s, input int px, input int py, input int gx, input int gy);
    bit near;
    bit hit_now;
    near    = absd(px, gx) < HIT && absd(py, gy) < HIT;
    hit_now = (m_st == 1) && near;
    m_caught = 0; m_resp = 0;
    case (m_st)
      0: if (s) begin m_st = 1; m_lives = LIVES; end
      1: if (m_hit) begin m_st = 2; m_lives--; m_left = FRZ - 1; m_caught = 1; end
      2: if (m_left == 0) begin
           if (m_lives > 0) begin m_st = 3; m_resp = 1; end
           else m_st = 4;
         end else m_left--;
      3: m_st = 1;
      4: if (s) begin m_st = 1; m_lives = LIVES; m_resp = 1; end
      default: ;
    endcase
    m_hit = hit_now;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},     32'(state),     32'(m_st));
    chk({tag, ".lives"},     32'(lives),     32'(m_lives));
    chk({tag, ".freeze"},    32'(freeze),    32'(m_st != 1));
    chk({tag, ".caught"},    32'(caught),    32'(m_caught));
    chk({tag, ".respawn"},   32'(respawn),   32'(m_resp));
    chk({tag, ".game_over"}, 32'(game_over), 32'(m_st == 4));
  endtask

  // Called at a negedge: check current outputs, drive inputs, advance one clock.
  task automatic cyc(input bit s, input int px, input int py, input int gx, input int gy);
    check_all("cyc");
    start = s; pac_x = 10'(px); pac_y = 9'(py); ghost_x = 10'(gx); ghost_y = 9'(gy);
    model_step(s, px, py, gx, gy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int budget;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1;

    // Start, then far apart for 100 cycles.
    cyc(1, 100, 100, 200, 146);
    chk("start_state", 32'(state), 32'd1);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_freeze", 32'(freeze), 32'd0);
    repeat (100) cyc(0, 100, 100, 200, 146);

    // Overlap held from cycle N onward.
    cyc(0, 100, 100, 107, 93);                       // N
    cyc(0, 100, 100, 107, 93);                       // N+1 edge: hit_q
    chk("catch1_caught", 32'(caught), 32'd1);        // after N+2 edge
    chk("catch1_state",  32'(state),  32'd2);
    chk("catch1_lives",  32'(lives),  32'd2);
    repeat (4) cyc(0, 100, 100, 107, 93);
    chk("resp1_pulse", 32'(respawn), 32'd1);
    chk("resp1_state", 32'(state),   32'd3);
    cyc(0, 100, 100, 107, 93);
    chk("play_after_resp", 32'(state),  32'd1);
    chk("no_stale_catch",  32'(caught), 32'd0);
    repeat (2) cyc(0, 100, 100, 107, 93);
    chk("catch2_caught", 32'(caught), 32'd1);
    chk("catch2_lives",  32'(lives),  32'd1);

    // Separate, let the freeze run out, then boundary positions.
    repeat (10) cyc(0, 100, 100, 300, 300);
    repeat (4) cyc(0, 100, 100, 108, 100);
    repeat (4) cyc(0, 100, 100, 100, 92);
    chk("boundary_no_catch", 32'(lives), 32'd1);
    cyc(0, 100, 100, 93, 100);
    cyc(0, 100, 100, 300, 300);
    chk("catch3_caught", 32'(caught), 32'd1);
    chk("catch3_lives",  32'(lives),  32'd0);
    repeat (8) cyc(0, 100, 100, 300, 300);
    chk("over_state",     32'(state),     32'd4);
    chk("over_game_over", 32'(game_over), 32'd1);
    cyc(1, 100, 100, 300, 300);
    chk("restart_state",   32'(state),   32'd1);
    chk("restart_lives",   32'(lives),   32'd3);
    chk("restart_respawn", 32'(respawn), 32'd1);

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      int px, py, gx, gy;
      px = $urandom_range(600, 20);
      py = $urandom_range(460, 20);
      if ($urandom_range(1, 0) == 1) begin
        gx = px + $urandom_range(24, 0) - 12;
        gy = py + $urandom_range(24, 0) - 12;
      end else begin
        gx = $urandom_range(1023, 0);
        gy = $urandom_range(511, 0);
      end
      cyc($urandom_range(15, 0) == 0, px, py, gx, gy);
    end

    // Drive toward CAUGHT with timer at 2, then reset asynchronously.
    budget = 0;
    while (!(m_st == 2 && m_left == FRZ - 3) && budget < 200) begin
      cyc(m_st == 0 || m_st == 4, 100, 100, 100, 100);
      budget++;
    end
    chk("reach_caught_t2", 32'(budget < 200), 32'd1);
    #2 rst = 0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk);
    rst = 1;
    cyc(1, 100, 100, 300, 300);
    chk("post_reset_state", 32'(state), 32'd1);
    chk("post_reset_lives", 32'(lives), 32'd3);
    repeat (3) cyc(0, 100, 100, 300, 300);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
